mem: RTL and testbench
======================

MEM -- requirements
Module: mem

Interface
REQ-001 Parameter DATA_W, default 32: data and address width in bits.
REQ-002 Parameter DEPTH, default 64: number of 32-bit words stored.
REQ-003 Parameter ADDR_LSB, default 2: lowest address bit used for word selection; byte offset bits are ignored.
REQ-004 clk  input  1  the module's only clock; all state changes occur on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-006 ALUResult  input  32  byte address for both read and write.
REQ-007 WD  input  32  write data.
REQ-008 MemWrite  input  1  write enable; 1 = store WD at the addressed word on the next rising edge.
REQ-009 ReadData  output  32  contents of the addressed word.

Function
REQ-010 Storage SHALL be DEPTH words of DATA_W bits.
REQ-011 Word index SHALL be ALUResult[ADDR_LSB+log2(DEPTH)-1 : ADDR_LSB], i.e. bits [7:2] at defaults; 0xC selects word 3 and 0x3E selects word 15.
REQ-012 Bits [1:0] SHALL be ignored, so there is no misalignment fault; e.g. 0x3C, 0x3D, 0x3E and 0x3F all access word 15.
REQ-013 Address bits above the index SHALL be ignored, so addresses alias modulo DEPTH*4 bytes; e.g. 0x13E accesses word 15.
REQ-014 Read SHALL be combinational (zero latency): ReadData SHALL equal mem[index] continuously, with no clock involved.
REQ-015 Write: on a rising clk with MemWrite=1 and reset=0, mem[index] SHALL take the value of WD; no other word SHALL change.
REQ-016 With MemWrite=0, memory SHALL be unchanged whatever the values of WD and ALUResult.
REQ-017 Read during a write to the same address:
- before the edge, ReadData SHALL show the old value;
- after the edge, ReadData SHALL show the new value within the same delta-free combinational path.
REQ-018 A write SHALL take exactly one clock edge; back-to-back writes on consecutive cycles SHALL all be stored.
REQ-019 Inputs X/Z on MemWrite are outside this specification; the design is not required to define behaviour for them.

Reset
REQ-020 On a rising clk with reset=1, every word SHALL be cleared to 0x00000000.
REQ-021 Reset SHALL take priority over MemWrite: a write presented in the same cycle SHALL be discarded.
REQ-022 After reset, ReadData SHALL be 0 for every address.
REQ-023 Power-up contents SHALL be 0 in simulation (initialised storage), so reads before the first reset return 0.
REQ-024 Reset asserted in the middle of a sequence of writes SHALL discard all previously written data.

Structure
REQ-025 DATA_W, DEPTH and ADDR_LSB defaults, plus a derived INDEX_W = log2(DEPTH), SHALL live in a shared memory-parameters package.
REQ-026 The design SHALL be a single flat module with one storage array, one write/reset process and one combinational read assignment; no sub-module.

Verification
REQ-027 Reset 1 cycle, then ALUResult=0xC, MemWrite=0 -> ReadData=0.
REQ-028 ALUResult=0xC, WD=865486, MemWrite=1 for one edge, then MemWrite=0 -> ReadData=865486 (before the edge it reads 0).
REQ-029 ALUResult=0x3E, WD=77777, MemWrite=0 -> ReadData stays 0, and word 15 is unchanged on later reads.
REQ-030 Write 4554 at 0x3E, then read 0x3C, 0x3F and 0x13E -> each read returns 4554; read 0xC -> still 865486.
REQ-031 Write 0 at 0xC, then 4554 at 0xC on consecutive edges -> ReadData=0 after the first edge and 4554 after the second.
REQ-032 reset=1 together with MemWrite=1, WD=0x12345678, ALUResult=0x8 -> after the edge, all addresses read 0, including 0x8.

Source files
------------

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
//   Shared memory parameters for the data memory block.
//   MEM_DATA_W   : data and address width in bits
//   MEM_DEPTH    : number of words stored
//   MEM_ADDR_LSB : lowest byte-address bit used for word selection
//   MEM_INDEX_W  : word index width, log2(MEM_DEPTH)
// ---------------------------------------------------------------------------
package mem_pkg;

    localparam int unsigned MEM_DATA_W   = 32;
    localparam int unsigned MEM_DEPTH    = 64;
    localparam int unsigned MEM_ADDR_LSB = 2;
    localparam int unsigned MEM_INDEX_W  = $clog2(MEM_DEPTH);

endpackage : mem_pkg

// File: rtl/mem.sv
// ---------------------------------------------------------------------------
// mem
//   Word-addressed data memory with combinational read and synchronous
//   write. Byte-offset bits and address bits above the word index are
//   ignored, so addresses alias modulo DEPTH words.
//
//   Ports
//     clk       in   1       rising-edge clock
//     reset     in   1       synchronous active-high clear of every word
//     ALUResult in   DATA_W  byte address shared by read and write
//     WD        in   DATA_W  write data
//     MemWrite  in   1       write enable, store WD on next rising edge
//     ReadData  out  DATA_W  contents of the addressed word
// ---------------------------------------------------------------------------
module mem
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W   = MEM_DATA_W,
    parameter int unsigned DEPTH    = MEM_DEPTH,
    parameter int unsigned ADDR_LSB = MEM_ADDR_LSB
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] WD,
    input  logic              MemWrite,
    output logic [DATA_W-1:0] ReadData
);

    localparam int unsigned INDEX_W = $clog2(DEPTH);

    // Storage starts cleared so reads before the first reset return zero.
    logic [DATA_W-1:0] storage [DEPTH] = '{default: '0};

    logic [INDEX_W-1:0] index;

    // Only the index field selects a word; the remaining address bits are
    // intentionally discarded.
    logic unused_addr;
    assign unused_addr = ^ALUResult;

    assign index = ALUResult[ADDR_LSB +: INDEX_W];

    // Reset wins over a write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else if (MemWrite) begin
            storage[index] <= WD;
        end
    end

    assign ReadData = storage[index];

endmodule : mem

// File: tb/tb_mem.sv
// ---------------------------------------------------------------------------
// tb_mem
//   Self-checking bench for mem: directed scenarios followed by a random
//   sequence of reads, writes and resets compared against a word-array
//   model addressed with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_mem;

    localparam int unsigned WORDS = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ALUResult;
    logic [31:0] WD;
    logic        MemWrite;
    logic [31:0] ReadData;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [31:0] model [WORDS];

    mem dut (
        .clk       (clk),
        .reset     (reset),
        .ALUResult (ALUResult),
        .WD        (WD),
        .MemWrite  (MemWrite),
        .ReadData  (ReadData)
    );

    always #5 clk = ~clk;

    function automatic int unsigned widx(input logic [31:0] a);
        return (a / 4) % WORDS;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < int'(WORDS); i++) model[i] = 32'h0;
    endtask

    // Present a write at the falling edge, check the old value before the
    // rising edge and the new value just after it. MemWrite stays high so
    // consecutive calls form back-to-back writes.
    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        ALUResult = addr;
        WD        = data;
        MemWrite  = 1'b1;
        #1;
        chk({tag, "_pre"}, ReadData, model[widx(addr)]);
        @(posedge clk);
        #1;
        model[widx(addr)] = data;
        chk({tag, "_post"}, ReadData, data);
    endtask

    task automatic idle();
        @(negedge clk);
        MemWrite = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] addr);
        ALUResult = addr;
        #1;
        chk(tag, ReadData, model[widx(addr)]);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic        we;
        logic        rs;

        clear_model();
        reset     = 1'b0;
        MemWrite  = 1'b0;
        WD        = 32'h0;
        ALUResult = 32'h0;

        // Power-up contents read zero before any reset.
        rd("powerup_0x00", 32'h00);
        rd("powerup_0xFC", 32'hFC);

        // One reset cycle, then read 0xC.
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
        rd("reset_read_0xC", 32'h0C);

        // Single write of 865486 at 0xC.
        do_write("wr_0xC", 32'h0C, 32'd865486);
        idle();
        rd("read_0xC", 32'h0C);

        // MemWrite low must not disturb word 15.
        ALUResult = 32'h3E;
        WD        = 32'd77777;
        @(posedge clk);
        #1;
        chk("nowrite_0x3E", ReadData, 32'h0);
        @(posedge clk);
        #1;
        rd("nowrite_0x3C_later", 32'h3C);

        // Offset bits and upper bits alias onto the same word.
        do_write("wr_0x3E", 32'h3E, 32'd4554);
        idle();
        rd("alias_0x3C", 32'h3C);
        chk("alias_0x3C_val", ReadData, 32'd4554);
        rd("alias_0x3F", 32'h3F);
        chk("alias_0x3F_val", ReadData, 32'd4554);
        rd("alias_0x13E", 32'h13E);
        chk("alias_0x13E_val", ReadData, 32'd4554);
        rd("keep_0xC", 32'h0C);
        chk("keep_0xC_val", ReadData, 32'd865486);

        // Back-to-back writes on consecutive edges.
        do_write("b2b_first", 32'h0C, 32'd0);
        do_write("b2b_second", 32'h0C, 32'd4554);
        idle();
        rd("b2b_read", 32'h0C);

        // Reset in the same cycle as a write discards the write.
        @(negedge clk);
        reset     = 1'b1;
        MemWrite  = 1'b1;
        WD        = 32'h12345678;
        ALUResult = 32'h8;
        @(posedge clk);
        #1;
        clear_model();
        chk("rst_vs_write_0x8", ReadData, 32'h0);
        @(negedge clk);
        reset    = 1'b0;
        MemWrite = 1'b0;
        for (int i = 0; i < int'(WORDS); i++) begin
            ALUResult = 32'(i * 4);
            #1;
            n_checks++;
            assert (ReadData === 32'h0) else begin
                n_fail++;
                $error("FAIL rst_clear_word%0d observed=0x%08h expected=0x00000000", i, ReadData);
            end
        end

        // Random mix of writes, idle cycles and occasional resets.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            a  = $urandom;
            d  = $urandom;
            we = ($urandom_range(0, 2) != 0);
            rs = ($urandom_range(0, 39) == 0);
            ALUResult = a;
            WD        = d;
            MemWrite  = we;
            reset     = rs;
            #1;
            chk("rand_pre", ReadData, model[widx(a)]);
            @(posedge clk);
            #1;
            if (rs) clear_model();
            else if (we) model[widx(a)] = d;
            chk("rand_post", ReadData, model[widx(a)]);
            ALUResult = $urandom;
            #1;
            chk("rand_other", ReadData, model[widx(ALUResult)]);
        end

        @(negedge clk);
        reset    = 1'b0;
        MemWrite = 1'b0;
        for (int i = 0; i < int'(WORDS); i++) begin
            ALUResult = 32'(i * 4 + $urandom_range(0, 3));
            #1;
            chk("final_sweep", ReadData, model[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem
